// File: rtl/pistorm_bus_arbiter_pkg.sv
// pistorm_pkg: shared FSM state encoding and counter width for the bus arbiter.
//   arb_state_t : IDLE, WAIT_END, GRANT, EXT_OWN, RECOVER
//   ARB_CNT_W   : width of the shared grant-timeout / recovery counter
package pistorm_pkg;
  localparam int ARB_CNT_W = 5;
  typedef enum logic [2:0] {IDLE, WAIT_END, GRANT, EXT_OWN, RECOVER} arb_state_t;
endpackage

// File: rtl/pistorm_bus_arbiter_if.sv
// pistorm_bus_arbiter_if: 68K bus-mastership signals between the arbiter and the 68K side.
//   master : arbiter view (drives BG_n, hold, bus_oe_n, ext_active, timeout)
//   slave  : bus/engine view (drives M68K_CLK, BR_n, BGACK_n, bus_busy)
interface pistorm_bus_arbiter_if;
  logic M68K_CLK;
  logic M68K_BR_n;
  logic M68K_BGACK_n;
  logic bus_busy;
  logic M68K_BG_n;
  logic arb_hold;
  logic arb_bus_oe_n;
  logic arb_ext_active;
  logic arb_timeout;
  modport master (
    input  M68K_CLK, M68K_BR_n, M68K_BGACK_n, bus_busy,
    output M68K_BG_n, arb_hold, arb_bus_oe_n, arb_ext_active, arb_timeout
  );
  modport slave (
    output M68K_CLK, M68K_BR_n, M68K_BGACK_n, bus_busy,
    input  M68K_BG_n, arb_hold, arb_bus_oe_n, arb_ext_active, arb_timeout
  );
endinterface

// File: rtl/pistorm_bus_arbiter_sync_edge.sv
// pistorm_sync_edge: N-flop synchroniser with rise/fall strobes on the synchronised value.
//   clk, rst_n : sampling clock, async active-low reset (chain loads INIT)
//   d          : async input
//   q          : synchronised level; rise/fall: one-clk strobes on q edges
module pistorm_sync_edge #(
  parameter int   N    = 2,
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [N:0] sr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= {(N+1){INIT}};
    else sr <= {sr[N-1:0], d};
  assign q    = sr[N-1];
  assign rise = sr[N-1] & ~sr[N];
  assign fall = ~sr[N-1] & sr[N];
endmodule

// File: rtl/pistorm_bus_arbiter.sv
// pistorm_bus_arbiter: 68000 BR/BG/BGACK bus-mastership arbiter in the PI_CLK domain.
//   PI_CLK, RST_n : system clock, async active-low reset
//   bus (master)  : M68K_CLK/BR_n/BGACK_n/bus_busy in; BG_n/hold/bus_oe_n/ext_active/timeout out
//   Define ARB_TIMEOUT_EN to re-arbitrate when BGACK never follows BG.
module pistorm_bus_arbiter
  import pistorm_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int GRANT_TIMEOUT  = 16,
  parameter int RECOVER_CYCLES = 1
) (
  input logic PI_CLK,
  input logic RST_n,
  pistorm_bus_arbiter_if.master bus
);
  arb_state_t state;
  logic [ARB_CNT_W-1:0] cnt;
  logic c7m_fall, br_n_s, bgack_n_s;
  logic unused_c7m_lvl, unused_c7m_rise, unused_br_rise, unused_br_fall, unused_bgack_rise, unused_bgack_fall;
  pistorm_sync_edge #(.N(SYNC_STAGES), .INIT(1'b0)) u_c7m (
    .clk(PI_CLK), .rst_n(RST_n), .d(bus.M68K_CLK),
    .q(unused_c7m_lvl), .rise(unused_c7m_rise), .fall(c7m_fall)
  );
  pistorm_sync_edge #(.N(SYNC_STAGES), .INIT(1'b1)) u_br (
    .clk(PI_CLK), .rst_n(RST_n), .d(bus.M68K_BR_n),
    .q(br_n_s), .rise(unused_br_rise), .fall(unused_br_fall)
  );
  pistorm_sync_edge #(.N(SYNC_STAGES), .INIT(1'b1)) u_bgack (
    .clk(PI_CLK), .rst_n(RST_n), .d(bus.M68K_BGACK_n),
    .q(bgack_n_s), .rise(unused_bgack_rise), .fall(unused_bgack_fall)
  );
  wire br    = ~br_n_s;
  wire bgack = ~bgack_n_s;
`ifndef ARB_TIMEOUT_EN
  localparam int unused_grant_timeout = GRANT_TIMEOUT;
  assign bus.arb_timeout = 1'b0;
`endif
  always_ff @(posedge PI_CLK or negedge RST_n)
    if (!RST_n) begin
      state              <= IDLE;
      cnt                <= '0;
      bus.M68K_BG_n      <= 1'b1;
      bus.arb_hold       <= 1'b0;
      bus.arb_bus_oe_n   <= 1'b0;
      bus.arb_ext_active <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      bus.arb_timeout    <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      bus.arb_timeout <= 1'b0;
`endif
      case (state)
        IDLE:
          if (br) begin
            state        <= WAIT_END;
            bus.arb_hold <= 1'b1;
          end
        // a cycle the engine already started must finish before BG can assert
        WAIT_END:
          if (c7m_fall && !bus.bus_busy) begin
            if (!br) begin
              state        <= IDLE;
              bus.arb_hold <= 1'b0;
            end else begin
              state         <= GRANT;
              bus.M68K_BG_n <= 1'b0;
              cnt           <= '0;
            end
          end
        // drivers stay enabled while BG is out; they tristate only on BGACK
        GRANT:
          if (c7m_fall) begin
            if (bgack) begin
              state              <= EXT_OWN;
              bus.M68K_BG_n      <= 1'b1;
              bus.arb_bus_oe_n   <= 1'b1;
              bus.arb_ext_active <= 1'b1;
            end else if (!br) begin
              state         <= IDLE;
              bus.M68K_BG_n <= 1'b1;
              bus.arb_hold  <= 1'b0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt == ARB_CNT_W'(GRANT_TIMEOUT - 1)) begin
              state           <= WAIT_END;
              bus.M68K_BG_n   <= 1'b1;
              bus.arb_timeout <= 1'b1;
            end else cnt <= cnt + 1'b1;
`endif
          end
        EXT_OWN:
          if (c7m_fall && !bgack) begin
            state              <= RECOVER;
            cnt                <= ARB_CNT_W'(RECOVER_CYCLES - 1);
            bus.arb_bus_oe_n   <= 1'b0;
            bus.arb_ext_active <= 1'b0;
          end
        RECOVER:
          if (c7m_fall) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
            else if (br) begin
              state         <= GRANT;
              bus.M68K_BG_n <= 1'b0;
              cnt           <= '0;
            end else begin
              state        <= IDLE;
              bus.arb_hold <= 1'b0;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule
